// File: rtl/debounced_toggle_pkg.sv
// -----------------------------------------------------------------------------
// debounced_toggle_pkg
//   Shared definitions for the pushbutton blocks: debounce FSM state encoding,
//   the short debounce length used by simulation benches, and a helper that
//   maps an FSM state to the debounced button level.
// -----------------------------------------------------------------------------
package debounced_toggle_pkg;

    // Debounce FSM state encoding (kept as plain constants for legacy tools).
    localparam logic [1:0] ST_IDLE         = 2'd0;  // stable released
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;  // candidate press, counting
    localparam logic [1:0] ST_HELD         = 2'd2;  // stable pressed
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;  // candidate release, counting

    // Debounce length used by benches so a press resolves in a handful of cycles.
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    // Debounced level implied by a state: the level only changes once a
    // transition has been accepted, so both wait states report the old level.
    function automatic logic state_level(input logic [1:0] state);
        return (state == ST_HELD) || (state == ST_RELEASE_WAIT);
    endfunction

endpackage : debounced_toggle_pkg

// File: rtl/btn_synchronizer.sv
// -----------------------------------------------------------------------------
// btn_synchronizer
//   Multi-flop synchroniser bringing an asynchronous pushbutton into the clk
//   domain. Reused by the lab's button blocks.
// Ports
//   clk     in  1  system clock
//   rst     in  1  synchronous, active-high reset; clears every stage
//   btn_i   in  1  raw asynchronous button level
//   sync_o  out 1  synchronised level (last stage of the chain)
// -----------------------------------------------------------------------------
module btn_synchronizer #(
    parameter int SYNC_STAGES = 2   // legal range >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples its input from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule : btn_synchronizer

// File: rtl/debounced_toggle.sv
// -----------------------------------------------------------------------------
// debounced_toggle
//   T-flip-flop driven by a raw pushbutton: the button is synchronised,
//   debounced by a 4-state FSM with a stability counter, and every accepted
//   press (while en = 1) inverts toggle_out and emits a one-cycle pulse.
// Ports
//   clk           in  1  system clock, single domain
//   rst           in  1  synchronous, active-high reset
//   btn_in        in  1  raw asynchronous pushbutton, 1 = pressed
//   en            in  1  toggle enable, sampled in the cycle a press is accepted
//   toggle_out    out 1  stored bit, inverted on each enabled accepted press
//   toggle_pulse  out 1  one-cycle high on each enabled accepted press
//   btn_level     out 1  debounced button level
// All outputs come straight from flops; nothing combinational from btn_in/en.
// -----------------------------------------------------------------------------
module debounced_toggle
    import debounced_toggle_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1_000_000,  // legal range >= 2
    parameter int   CNT_W           = 20,         // 2**CNT_W > DEBOUNCE_CYCLES
    parameter int   SYNC_STAGES     = 2,          // legal range >= 2
    parameter logic INIT_STATE      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic en,
    output logic toggle_out,
    output logic toggle_pulse,
    output logic btn_level
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             toggle_q, toggle_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             press_accept;

    btn_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_in),
        .sync_o (s)
    );

    // The counter holds the number of consecutive cycles s has shown the new
    // level; entering a wait state counts the first such cycle, so acceptance
    // happens when the DEBOUNCE_CYCLES-th stable sample is seen. Any reversal
    // clears it, so it never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        press_accept = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_HELD;
                    cnt_d        = '0;
                    press_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Only an enabled press acts; release acceptance never toggles.
        pulse_d  = press_accept & en;
        toggle_d = toggle_q ^ pulse_d;
        level_d  = state_level(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            toggle_q <= INIT_STATE;
            pulse_q  <= 1'b0;
            level_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            toggle_q <= toggle_d;
            pulse_q  <= pulse_d;
            level_q  <= level_d;
        end
    end

    assign toggle_out   = toggle_q;
    assign toggle_pulse = pulse_q;
    assign btn_level    = level_q;

endmodule : debounced_toggle

// File: tb/tb_debounced_toggle.sv
// -----------------------------------------------------------------------------
// tb_debounced_toggle
//   Table-driven bench: one row per clock cycle holding the inputs applied
//   before a rising edge and the {toggle_pulse, toggle_out, btn_level} expected
//   just after that edge. DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2, INIT_STATE = 0.
//   With btn_in first sampled high at edge k, s is high after edge k+1, the
//   FSM enters PRESS_WAIT at k+2 and accepts at k+5: five rows of "waiting"
//   then the accept row. Releases follow the same five-row latency.
// -----------------------------------------------------------------------------
module tb_debounced_toggle;
    import debounced_toggle_pkg::*;

    typedef struct {
        logic       rst;
        logic       btn;
        logic       en;
        logic [2:0] exp;   // {toggle_pulse, toggle_out, btn_level}
        string      tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic en = 1'b1;
    logic toggle_out, toggle_pulse, btn_level;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   t6_pulses = 0;

    always #5 clk = ~clk;

    debounced_toggle #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
        .CNT_W           (3),
        .SYNC_STAGES     (2),
        .INIT_STATE      (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .en           (en),
        .toggle_out   (toggle_out),
        .toggle_pulse (toggle_pulse),
        .btn_level    (btn_level)
    );

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: pulse/out/level got %b, expected %b", name, act, exp);
        end
    endtask

    // Append n identical rows.
    task automatic vr(input int n, input logic r, input logic b, input logic e,
                      input logic p, input logic o, input logic l, input string tag);
        vec_t v;
        v.rst = r; v.btn = b; v.en = e; v.exp = {p, o, l}; v.tag = tag;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Clean release from HELD: five rows at level 1, then five at level 0.
    task automatic release_rows(input logic o, input string tag);
        vr(5, 0, 0, 1, 0, o, 1, {tag, "_rel_wait"});
        vr(5, 0, 0, 1, 0, o, 0, {tag, "_released"});
    endtask

    initial begin
        // Reset
        vr(2, 1, 0, 1, 0, 0, 0, "reset");
        // T1 clean press, held 20 cycles
        vr(5,  0, 1, 1, 0, 0, 0, "t1_wait");
        vr(1,  0, 1, 1, 1, 1, 1, "t1_accept");
        vr(14, 0, 1, 1, 0, 1, 1, "t1_held");
        // T3 release, then re-press toggles 1 -> 0
        release_rows(1, "t3a");
        vr(5, 0, 1, 1, 0, 1, 0, "t3_wait");
        vr(1, 0, 1, 1, 1, 0, 1, "t3_accept");
        vr(4, 0, 1, 1, 0, 0, 1, "t3_held");
        release_rows(0, "t3b");
        // T2 glitch: 3 cycles high is one short of acceptance
        vr(3, 0, 1, 1, 0, 0, 0, "t2_glitch");
        vr(6, 0, 0, 1, 0, 0, 0, "t2_after");
        // Exactly 4 cycles high is the shortest accepted press
        vr(4, 0, 1, 1, 0, 0, 0, "b4_high");
        vr(1, 0, 0, 1, 0, 0, 0, "b4_low");
        vr(1, 0, 0, 1, 1, 1, 1, "b4_accept");
        vr(3, 0, 0, 1, 0, 1, 1, "b4_rel_wait");
        vr(3, 0, 0, 1, 0, 1, 0, "b4_released");
        // T5 reset two cycles after s rises, button kept held
        vr(3, 0, 1, 1, 0, 1, 0, "t5_press");
        vr(1, 1, 1, 1, 0, 0, 0, "t5_reset");
        vr(5, 0, 1, 1, 0, 0, 0, "t5_wait");
        vr(1, 0, 1, 1, 1, 1, 1, "t5_accept");
        vr(4, 0, 1, 1, 0, 1, 1, "t5_held");
        release_rows(1, "t5");
        // T4 enable gating: en = 0 press only moves btn_level
        vr(5, 0, 1, 0, 0, 1, 0, "t4_wait_en0");
        vr(1, 0, 1, 0, 0, 1, 1, "t4_accept_en0");
        vr(4, 0, 1, 0, 0, 1, 1, "t4_held_en0");
        release_rows(1, "t4a");
        vr(5, 0, 1, 1, 0, 1, 0, "t4_wait_en1");
        vr(1, 0, 1, 1, 1, 0, 1, "t4_accept_en1");
        vr(4, 0, 1, 1, 0, 0, 1, "t4_held_en1");
        release_rows(0, "t4b");
        // en is only sampled in the accept cycle
        vr(5, 0, 1, 1, 0, 0, 0, "t4_wait_gate");
        vr(1, 0, 1, 0, 0, 0, 1, "t4_accept_en_low");
        vr(4, 0, 1, 1, 0, 0, 1, "t4_held_gate");
        release_rows(0, "t4c");
        // T6 bounce burst: 12 alternating cycles, then stable high
        for (int i = 0; i < 12; i++) vr(1, 0, (i % 2 == 0), 1, 0, 0, 0, "t6_bounce");
        vr(5, 0, 1, 1, 0, 0, 0, "t6_settle");
        vr(1, 0, 1, 1, 1, 1, 1, "t6_accept");
        vr(4, 0, 1, 1, 0, 1, 1, "t6_held");
        release_rows(1, "t6");
        // Reset on the would-be accept cycle wins: no pulse, out back to INIT
        vr(5, 0, 1, 1, 0, 1, 0, "rst_press");
        vr(1, 1, 1, 1, 0, 0, 0, "rst_at_accept");
        vr(3, 0, 0, 1, 0, 0, 0, "rst_after");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst    = vecs[i].rst;
            btn_in = vecs[i].btn;
            en     = vecs[i].en;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", vecs[i].tag, i),
                  {toggle_pulse, toggle_out, btn_level}, vecs[i].exp);
            if (vecs[i].tag.substr(0, 1) == "t6" && toggle_pulse === 1'b1) t6_pulses++;
        end

        // The whole bounce burst must collapse into a single press.
        check("t6_pulse_count", 3'(t6_pulses), 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_debounced_toggle
